// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the rv_lsu load/store unit: funct3 encodings, FSM states
// and the byte-enable / legality helpers used by the top and the load aligner.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Half uses a[1] and word uses lane 0, so low address bits are naturally aligned.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    if (is_store) begin
      ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] a);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv_lsu_load_align.sv
// Combinational load data alignment: picks the addressed byte/half of the read word
// and sign- or zero-extends it according to funct3.
import rv_lsu_pkg::*;

module rv_lsu_load_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    case (a_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      2'b11:   byte_s = word_i[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = a_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {24'd0, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LHU:  data_o = {16'd0, half_s};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// RV32I load/store unit: one memory transaction per start over a req/ready handshake.
// Build option RV_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
import rv_lsu_pkg::*;

module rv_lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] alu_r_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ready_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  state_e          state_q, state_d;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] align_s, rep_s;
  logic            misalign_s, timeout_s, req_s;

`ifdef RV_LSU_MISALIGN_TRAP_EN
  assign misalign_s = misaligned(funct3_i, alu_r_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign timeout_s = (TIMEOUT != 32'd0) && (cnt_q == TIMEOUT - 32'd1);

  rv_lsu_load_align u_align (
    .funct3_i (funct3_q),
    .a_i      (addr_q[1:0]),
    .word_i   (mem_rdata_i),
    .data_o   (align_s)
  );

  // Next-state, timeout counter and load-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = 32'd0;
          if (!f3_legal(is_store_i, funct3_i) || misalign_s) begin
            state_d = FAULT;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          state_d = DONE;
          if (!is_store_q) begin
            rdata_d = align_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, result and captured request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if ((state_q == IDLE) && start_i) begin
        is_store_q <= is_store_i;
        funct3_q   <= funct3_i;
        addr_q     <= alu_r_i;
        wdata_q    <= wdata_i;
      end
    end
  end

  // Store data replicated across every lane the access size can land in.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   rep_s = {4{wdata_q[7:0]}};
      2'b01:   rep_s = {2{wdata_q[15:0]}};
      default: rep_s = wdata_q;
    endcase
  end

  assign req_s       = (state_q == REQ);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE) || (state_q == FAULT);
  assign fault_o     = (state_q == FAULT);
  assign rdata_o     = rdata_q;
  assign mem_req_o   = req_s;
  assign mem_we_o    = req_s && is_store_q;
  assign mem_addr_o  = req_s ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_be_o    = req_s ? be_gen(funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_wdata_o = req_s ? rep_s : '0;

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed cases plus randomized accesses against a
// size/offset arithmetic model; a second instance with TIMEOUT = 4 covers the abort path.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_r = 32'd0, wdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        a_busy, a_done, a_fault, a_req, a_we;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_busy, b_done, b_fault, b_req, b_we;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_be;

  logic        sel = 1'b0;
  logic        o_busy, o_done, o_fault, o_req, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rd_a = 32'd0, exp_rd_b = 32'd0;

  always #5 clk = ~clk;

  rv_lsu u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .is_store_i(is_store), .funct3_i(funct3),
    .alu_r_i(alu_r), .wdata_i(wdata), .busy_o(a_busy), .done_o(a_done), .fault_o(a_fault),
    .rdata_o(a_rdata), .mem_req_o(a_req), .mem_we_o(a_we), .mem_addr_o(a_addr),
    .mem_be_o(a_be), .mem_wdata_o(a_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  rv_lsu #(.TIMEOUT(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .is_store_i(is_store), .funct3_i(funct3),
    .alu_r_i(alu_r), .wdata_i(wdata), .busy_o(b_busy), .done_o(b_done), .fault_o(b_fault),
    .rdata_o(b_rdata), .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_addr),
    .mem_be_o(b_be), .mem_wdata_o(b_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_fault = sel ? b_fault : a_fault;
  assign o_req   = sel ? b_req   : a_req;
  assign o_we    = sel ? b_we    : a_we;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_be    = sel ? b_be    : a_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(o_busy),  32'd0);
    chk({tag, ".done"},  32'(o_done),  32'd0);
    chk({tag, ".fault"}, 32'(o_fault), 32'd0);
    chk({tag, ".rdata"}, o_rdata,      32'd0);
    chk({tag, ".req"},   32'(o_req),   32'd0);
    chk({tag, ".we"},    32'(o_we),    32'd0);
    chk({tag, ".addr"},  o_addr,       32'd0);
    chk({tag, ".be"},    32'(o_be),    32'd0);
    chk({tag, ".wdata"}, o_wdata,      32'd0);
  endtask

  // Reference: access size and byte offset drive lanes, replication and extension.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] prev,
                       output logic flt, output logic [3:0] be, output logic [31:0] wdo,
                       output logic [31:0] rdo);
    int sz, off;
    logic [63:0] m, v;
    flt = st ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 >= 3'd6));
    be = 4'd0; wdo = 32'd0; rdo = prev;
    if (!flt) begin
      sz  = 1 << f3[1:0];
      off = int'(addr[1:0]);
`ifdef RV_LSU_MISALIGN_TRAP_EN
      if (off % sz != 0) flt = 1'b1;
`endif
      off = off - off % sz;
      m   = (64'd1 << (8 * sz)) - 64'd1;
      be  = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4 / sz; i++) wdo = wdo | 32'((64'(wd) & m) << (8 * sz * i));
      v = (64'(rd) >> (8 * off)) & m;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~m;
      if (!st && !flt) rdo = v[31:0];
    end
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input int dly, input logic pulse);
    logic flt;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_rd, prev;
    prev = sel ? exp_rd_b : exp_rd_a;
    model(st, f3, addr, wd, rd, prev, flt, e_be, e_wd, e_rd);
    is_store = st; funct3 = f3; alu_r = addr; wdata = wd; mem_ready = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    is_store = 1'($urandom); funct3 = 3'($urandom); alu_r = $urandom; wdata = $urandom;
    if (flt) begin
      chk({tag, ".f_done"},  32'(o_done),  32'd1);
      chk({tag, ".f_fault"}, 32'(o_fault), 32'd1);
      chk({tag, ".f_req"},   32'(o_req),   32'd0);
      chk({tag, ".f_rdata"}, o_rdata,      prev);
      if (pulse) begin if (sel) start_b = 1'b1; else start_a = 1'b1; end
      step();
      chk({tag, ".f_done2"}, 32'(o_done), 32'd0);
      chk({tag, ".f_busy2"}, 32'(o_busy), 32'd0);
    end else begin
      chk({tag, ".req"},  32'(o_req),  32'd1);
      chk({tag, ".done0"}, 32'(o_done), 32'd0);
      chk({tag, ".addr"}, o_addr,      {addr[31:2], 2'b00});
      chk({tag, ".be"},   32'(o_be),   32'(e_be));
      chk({tag, ".we"},   32'(o_we),   32'(st));
      if (st) chk({tag, ".wdata"}, o_wdata, e_wd);
      if (pulse) begin if (sel) start_b = 1'b1; else start_a = 1'b1; end
      for (int i = 0; i < dly; i++) begin
        mem_rdata = $urandom;
        step();
        chk({tag, ".stall_req"},  32'(o_req),  32'd1);
        chk({tag, ".stall_addr"}, o_addr,      {addr[31:2], 2'b00});
        chk({tag, ".stall_be"},   32'(o_be),   32'(e_be));
        chk({tag, ".stall_done"}, 32'(o_done), 32'd0);
        if (st) chk({tag, ".stall_wdata"}, o_wdata, e_wd);
      end
      mem_ready = 1'b1; mem_rdata = rd;
      step();
      mem_ready = 1'b0; mem_rdata = $urandom;
      chk({tag, ".done"},  32'(o_done),  32'd1);
      chk({tag, ".fault"}, 32'(o_fault), 32'd0);
      chk({tag, ".req_off"}, 32'(o_req), 32'd0);
      chk({tag, ".rdata"}, o_rdata,      e_rd);
      step();
      chk({tag, ".done2"}, 32'(o_done), 32'd0);
      chk({tag, ".busy2"}, 32'(o_busy), 32'd0);
    end
    if (sel) exp_rd_b = e_rd; else exp_rd_a = e_rd;
  endtask

  initial begin
    step(); step();
    sel = 1'b0; chk_idle("rst_a");
    sel = 1'b1; chk_idle("rst_b");
    rst = 1'b0;
    sel = 1'b0;
    step();

    txn("sw",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    txn("lb",  1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("lb.val", a_rdata, 32'hFFFF_FF80);
    txn("lbu", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h8011_2233, 1, 1'b0);
    chk("lbu.val", a_rdata, 32'h0000_0080);
    txn("sh",  1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 5, 1'b0);
    txn("lh_misal", 1'b0, 3'b001, 32'h0000_0401, 32'h0, 32'h1234_F678, 2, 1'b1);
    txn("f3_011", 1'b0, 3'b011, 32'h0000_0600, 32'h0, 32'h0, 0, 1'b0);
    txn("sbu_ill", 1'b1, 3'b100, 32'h0000_0604, 32'h5, 32'h0, 0, 1'b0);

    // Timeout instance: seed a known rdata, then stall until abort.
    sel = 1'b1;
    txn("b_lw", 1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h1234_5678, 0, 1'b0);
    is_store = 1'b0; funct3 = 3'b010; alu_r = 32'h0000_0704; mem_ready = 1'b0;
    start_b = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to.req", 32'(b_req), 32'd1);
      chk("to.done0", 32'(b_done), 32'd0);
      step();
    end
    chk("to.req_drop", 32'(b_req),   32'd0);
    chk("to.done",     32'(b_done),  32'd1);
    chk("to.fault",    32'(b_fault), 32'd1);
    chk("to.rdata",    b_rdata,      32'h1234_5678);
    step();
    chk("to.done2", 32'(b_done), 32'd0);
    chk("to.busy2", 32'(b_busy), 32'd0);

    // Reset during a stalled request aborts silently and clears rdata.
    sel = 1'b0;
    txn("lw_seed", 1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    is_store = 1'b0; funct3 = 3'b010; alu_r = 32'h0000_0900; mem_ready = 1'b0;
    start_a = 1'b1;
    step();
    chk("rr.req", 32'(a_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rr");
    exp_rd_a = 32'd0;
    step();
    chk("rr.done_after", 32'(a_done), 32'd0);
    chk("rr.busy_after", 32'(a_busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      txn("rnd", 1'($urandom), 3'($urandom_range(7, 0)), $urandom, $urandom, $urandom,
          int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit in the RV32I execute/memory path, directly downstream of the ALU.
- Consumes the ALU result as the effective address (rs1 + imm) and rs2 as store data.
- Runs one data-memory transaction over a req/ready handshake; generates byte enables for stores; aligns and sign/zero-extends load data.
- Returns rdata plus a one-cycle done pulse for writeback and pipeline stall release.

Parameters:
- TIMEOUT, 255, max cycles mem_req may wait for mem_ready before abort; 0 = never time out.
- XLEN, 32, data/address width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch access; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I load/store funct3
- alu_r  in  32  effective address from ALU
- wdata  in  32  rs2 store data
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; illegal funct3, misaligned (macro) or timeout
- rdata  out  32  extended load result
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accept/complete
- mem_rdata  in  32  read word, valid when mem_ready

Behaviour:
- Reset: state = IDLE; all outputs 0, including rdata; timeout counter 0. Reset mid-transaction aborts it without a done pulse.
- States:
  - IDLE: on start, register is_store, funct3, alu_r and wdata, then go to REQ or FAULT.
  - REQ: mem_req = 1; address, we, be and wdata stay stable until mem_ready. On mem_ready go to DONE and capture load data. On counter == TIMEOUT-1 without mem_ready, go to FAULT.
  - DONE: done = 1 for one cycle, then IDLE.
  - FAULT: done = 1 and fault = 1 for one cycle, then IDLE; no memory request is issued.
- Latency: start at cycle N gives mem_req at N+1. With mem_ready at N+1, done is at N+2, so the minimum access is 2 cycles.
- Illegal funct3 goes straight to FAULT:
  - Loads: 011, 110, 111.
  - Stores: any funct3 other than 000/001/010.
- start while busy is ignored; there is no queueing.
- mem_addr = {alu_r[31:2], 2'b00}.
- Store byte enables and data:
  - SB: be = 1 << a[1:0]; wdata[7:0] replicated into all 4 lanes.
  - SH: be = 0011 when a[1] = 0, else 1100; wdata[15:0] replicated into both halves.
  - SW: be = 1111.
- Load byte enables:
  - LB/LBU use the byte lane a[1:0].
  - LH/LHU use the half at a[1].
  - LW uses the full word.
  - For all loads, be still reflects the accessed lanes and mem_we = 0.
- rdata:
  - Loaded only in REQ on mem_ready for loads: LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores and faults leave rdata unchanged.
- Timeout counter clears on entry to REQ. TIMEOUT = 0 disables it.

Optional Feature:
- Macro: RV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with a[0] = 1, or word with a[1:0] != 0, goes to FAULT.
  - No mem_req is issued.
- Undefined:
  - Low address bits are forced to natural alignment: half uses a[1], word uses lane 0.
  - The access completes normally with fault = 0.

Decomposition:
- Shared package rv_lsu_pkg:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum IDLE/REQ/DONE/FAULT.
  - Byte-enable function be_gen(funct3, a[1:0]).
- One natural sub-module, rv_lsu_load_align: combinational lane select plus sign/zero extension.

Test Plan:
- SW, alu_r = 0x100, wdata = 0xDEADBEEF, mem_ready same cycle as req: mem_addr = 0x100, be = 1111, we = 1, done at start+2, fault = 0.
- LB, alu_r = 0x203, mem_rdata = 0x80112233: be = 1000, rdata = 0xFFFFFF80. Same access as LBU gives rdata = 0x00000080.
- SH, alu_r = 0x302, wdata = 0x0000ABCD: be = 1100, mem_wdata = 0xABCDABCD. Hold mem_ready low 5 cycles: req and bus stay stable, done one cycle after ready.
- LW with TIMEOUT = 4 and mem_ready held 0: mem_req drops after 4 cycles, done = fault = 1 for one cycle, rdata unchanged.
- LH, alu_r = 0x401, then start pulsed during busy:
  - Macro defined: immediate fault, no mem_req.
  - Macro undefined: be = 0011 and normal done.
  - In both cases the second start is ignored.
- funct3 = 011 load, then rst asserted during a stalled REQ: first gives fault; reset returns IDLE with all outputs 0 and no done.
